note_sequencer: RTL

- Upstream stage of the square-wave oscillator.
- Steps through a 16-entry writable note pattern at a fixed tempo.
- Drives the oscillator's 2-bit note select and a GATE that downstream logic uses to mute AUDIO during rests and inter-note gaps.
- Provides start/stop/loop control and status for the top-level controller.

---
 rtl/note_sequencer_if.sv | 26 ++
 rtl/note_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/note_sequencer_if.sv
// Control/status bundle between the top-level controller and the note sequencer.
// The controller drives playback control and pattern writes; the sequencer returns note/gate/status.
interface note_sequencer_if;
  logic       start;
  logic       stop;
  logic       loop;
  logic [3:0] length;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [2:0] wr_data;
  logic [1:0] note_sel;
  logic       gate;
  logic [3:0] step;
  logic       playing;
  logic       done;

  modport master (
    output start, stop, loop, length, wr_en, wr_addr, wr_data,
    input  note_sel, gate, step, playing, done
  );

  modport slave (
    input  start, stop, loop, length, wr_en, wr_addr, wr_data,
    output note_sel, gate, step, playing, done
  );
endinterface

// File: rtl/note_sequencer.sv
// Steps through a 16-entry {rest, note} pattern at a fixed tempo, driving the oscillator note
// select and an audio gate that is forced low for a short gap at the end of every step.
module note_sequencer #(
  parameter int BEAT_CYCLES = 2_500_000,
  parameter int GAP_CYCLES  = 250_000,
  parameter int CNT_W       = 22
) (
  input  logic             clk,
  input  logic             rst_n,
  note_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       pattern [16];

  logic [1:0] note_q, note_nxt;
  logic       gate_q, gate_nxt;
  logic [3:0] step_q, step_nxt;
  logic       done_q, done_nxt;

  logic       beat_end;
  logic       gap_hit;
  logic       last_step;
  logic       load;
  logic [3:0] load_idx;

  assign beat_end = (cnt == CNT_LAST);
  assign gap_hit  = (cnt == CNT_GAP);
  // A step past LENGTH (LENGTH lowered mid-play) keeps advancing until the index tops out at 15.
  assign last_step = (step_q == bus.length) || (step_q == 4'hF);

  // Pattern RAM: reads during a load see the pre-write contents of the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) pattern[i] <= 3'b100;
    end else if (bus.wr_en) begin
      pattern[bus.wr_addr] <= bus.wr_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      note_q <= 2'd0;
      gate_q <= 1'b0;
      step_q <= 4'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      note_q <= note_nxt;
      gate_q <= gate_nxt;
      step_q <= step_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.start && !bus.stop) state_nxt = PLAY;
      PLAY: begin
        if (bus.stop)                                       state_nxt = IDLE;
        else if (!bus.start && beat_end && last_step && !bus.loop) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt  = cnt;
    note_nxt = note_q;
    gate_nxt = gate_q;
    step_nxt = step_q;
    done_nxt = 1'b0;
    load     = 1'b0;
    load_idx = 4'd0;
    unique case (state)
      IDLE: begin
        cnt_nxt  = '0;
        gate_nxt = 1'b0;
        if (bus.start && !bus.stop) load = 1'b1;
      end
      PLAY: begin
        if (bus.stop) begin
          cnt_nxt  = '0;
          gate_nxt = 1'b0;
        end else if (bus.start) begin
          load = 1'b1;
        end else if (beat_end) begin
          if (!last_step) begin
            load     = 1'b1;
            load_idx = 4'(step_q + 4'd1);
          end else if (bus.loop) begin
            load = 1'b1;
          end else begin
            cnt_nxt  = '0;
            gate_nxt = 1'b0;
            done_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt + CNT_ONE;
          if (gap_hit) gate_nxt = 1'b0;
        end
      end
      default: begin
        cnt_nxt  = '0;
        gate_nxt = 1'b0;
      end
    endcase
    if (load) begin
      step_nxt = load_idx;
      note_nxt = pattern[load_idx][1:0];
      gate_nxt = ~pattern[load_idx][2];
      cnt_nxt  = '0;
    end
  end

  assign bus.note_sel = note_q;
  assign bus.gate     = gate_q;
  assign bus.step     = step_q;
  assign bus.playing  = (state == PLAY);
  assign bus.done     = done_q;

endmodule
